// File: rtl/probador_compuerta.sv
// probador_compuerta: on-chip truth-table tester for small combinational gates.
// After start, drives every input combination onto o_vec_out in turn and holds each one for
// SETTLE cycles. On the following cycle it compares i_f_in with the expected bit from TABLA.
// Once the whole sweep is done it reports the mismatch count, the lowest failing vector and
// a pass flag.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_start       start a sweep (level; only acted on while idle or done)
//   o_vec_out     vector driven to the gate under test (bit 0 = a, bit 1 = b, ...)
//   i_f_in        gate output, combinational from o_vec_out
//   o_busy        sweep in progress
//   o_done        sweep finished, results valid until restart/reset
//   o_pass        done with zero mismatches
//   o_err_count   number of mismatching vectors (0 .. 2**N_IN)
//   o_first_fail  lowest mismatching vector index (valid when o_err_count > 0)
module probador_compuerta #(
    parameter int unsigned           N_IN   = 2,
    parameter logic [2**N_IN-1:0]    TABLA  = 4'b1000,
    parameter int unsigned           SETTLE = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    output logic [N_IN-1:0] o_vec_out,
    input  logic            i_f_in,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [N_IN:0]   o_err_count,
    output logic [N_IN-1:0] o_first_fail
);

    localparam int unsigned N_VEC = 2 ** N_IN;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned ERR_W = N_IN + 1;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [N_IN-1:0]     r_vec;
    logic [N_IN-1:0]     w_vec_d;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_d;
    logic                r_busy;
    logic                w_busy_d;
    logic                r_done;
    logic                w_done_d;
    logic                r_pass;
    logic                w_pass_d;
    logic [ERR_W-1:0]    r_err;
    logic [ERR_W-1:0]    w_err_d;
    logic [N_IN-1:0]     r_first;
    logic [N_IN-1:0]     w_first_d;

    logic                w_expected;
    logic                w_mismatch;

    assign w_expected = TABLA[r_vec];
    // Case inequality so an X/Z gate output is reported as a mismatch in simulation.
    assign w_mismatch = (i_f_in !== w_expected);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_first <= '0;
        end else begin
            r_state <= w_state_d;
            r_vec   <= w_vec_d;
            r_cnt   <= w_cnt_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
            r_pass  <= w_pass_d;
            r_err   <= w_err_d;
            r_first <= w_first_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_vec_d   = r_vec;
        w_cnt_d   = r_cnt;
        w_busy_d  = r_busy;
        w_done_d  = r_done;
        w_pass_d  = r_pass;
        w_err_d   = r_err;
        w_first_d = r_first;

        case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_state_d = StSettle;
                    w_vec_d   = '0;
                    w_cnt_d   = '0;
                    w_busy_d  = 1'b1;
                    w_done_d  = 1'b0;
                    w_pass_d  = 1'b0;
                    w_err_d   = '0;
                    w_first_d = '0;
                end
            end
            StSettle: begin
                if (r_cnt == CNT_W'(SETTLE - 1)) begin
                    w_state_d = StCheck;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d   = r_cnt + CNT_W'(1);
                end
            end
            StCheck: begin
                if (w_mismatch) begin
                    w_err_d = r_err + ERR_W'(1);
                    if (r_err == '0) begin
                        w_first_d = r_vec;
                    end
                end
                if (r_vec == N_IN'(N_VEC - 1)) begin
                    w_state_d = StDone;
                    w_busy_d  = 1'b0;
                    w_done_d  = 1'b1;
                    w_pass_d  = (w_err_d == '0);
                end else begin
                    w_state_d = StSettle;
                    w_vec_d   = r_vec + N_IN'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign o_vec_out    = r_vec;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_count  = r_err;
    assign o_first_fail = r_first;

endmodule
